mult_ctrl: RTL and testbench

//  Sequencing FSM for the add-shift signed multiplier datapath (A/B register pair plus sign bit X).

---
 rtl/mult_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mult_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// -----------------------------------------------------------------------------
// mult_ctrl
// Sequencing FSM for the add-shift signed multiplier datapath (X:A:B).
// For each multiplier bit it issues one ADD cycle (conditional add of S into
// X:A, a subtract on the final bit) followed by one SHIFT cycle (X:A:B >> 1).
// It also handles the operand clear/load request and the Run/Done handshake.
//
// Optional feature: define MULT_CTRL_AUTOCLR_EN to insert a CLEAR cycle at the
// start of every multiply so X:A starts at zero each time. Without it, X:A is
// cleared only by ClearA_LoadB in IDLE, so repeated Run chains multiplies.
//
// Parameters
//   WIDTH        operand width, also the number of add/shift iterations (>=2)
// Ports
//   Clk          in  clock
//   Reset        in  synchronous, active-high reset
//   Run          in  start request (level); must drop after Done to re-arm
//   ClearA_LoadB in  in IDLE: clear X:A and load B from the switches
//   M            in  current multiplier LSB (B[0])
//   Clr_XA       out clear X and A this cycle
//   Ld_XA        out load adder result into X:A this cycle
//   Ld_B         out load B from switch data this cycle
//   Shift_En     out shift X:A:B right by one this cycle
//   Fn           out adder function: 0 = A+S, 1 = A-S
//   Busy         out high while a multiply is in progress
//   Done         out high while the product is held in A:B
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_XA,
  output logic Ld_B,
  output logic Shift_En,
  output logic Fn,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef MULT_CTRL_AUTOCLR_EN
    S_CLEAR = 3'd1,
`endif
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  logic clr_xa_s;
  logic ld_xa_s;
  logic ld_b_s;
  logic shift_en_s;
  logic fn_s;
  logic busy_s;
  logic done_s;

  // State and iteration counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, counter update and raw (ungated) control outputs.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    clr_xa_s   = 1'b0;
    ld_xa_s    = 1'b0;
    ld_b_s     = 1'b0;
    shift_en_s = 1'b0;
    fn_s       = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;

    case (state_r)
      S_IDLE: begin
        // A start request takes priority over a pending clear/load.
        if (Run) begin
          cnt_s = CNT_ZERO;
`ifdef MULT_CTRL_AUTOCLR_EN
          state_s = S_CLEAR;
`else
          state_s = S_ADD;
`endif
        end else begin
          ld_b_s   = ClearA_LoadB;
          clr_xa_s = ClearA_LoadB;
        end
      end

`ifdef MULT_CTRL_AUTOCLR_EN
      S_CLEAR: begin
        clr_xa_s = 1'b1;
        busy_s   = 1'b1;
        state_s  = S_ADD;
      end
`endif

      S_ADD: begin
        // The top multiplier bit carries negative weight, hence subtract.
        ld_xa_s = M;
        fn_s    = (cnt_r == CNT_LAST);
        busy_s  = 1'b1;
        state_s = S_SHIFT;
      end

      S_SHIFT: begin
        shift_en_s = 1'b1;
        busy_s     = 1'b1;
        // The counter is left at its last value so it saturates in HOLD.
        if (cnt_r == CNT_LAST) begin
          state_s = S_HOLD;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = S_ADD;
        end
      end

      S_HOLD: begin
        done_s = 1'b1;
        if (Run) begin
          state_s = S_HOLD;
        end else begin
          state_s = S_IDLE;
        end
      end

      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Force every output low while Reset is asserted, whatever the inputs.
  always_comb begin
    if (Reset) begin
      Clr_XA   = 1'b0;
      Ld_XA    = 1'b0;
      Ld_B     = 1'b0;
      Shift_En = 1'b0;
      Fn       = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
    end else begin
      Clr_XA   = clr_xa_s;
      Ld_XA    = ld_xa_s;
      Ld_B     = ld_b_s;
      Shift_En = shift_en_s;
      Fn       = fn_s;
      Busy     = busy_s;
      Done     = done_s;
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_ctrl
// Self-checking bench for mult_ctrl. A step-based model predicts every control
// output each cycle; a small register-unit model (X:A:B plus adder) is driven
// by the DUT controls and supplies M, so finished products can be compared to
// hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mult_ctrl;

  localparam int W = 8;
`ifdef MULT_CTRL_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif
  localparam int LAT = 2 * W + (AUTOCLR ? 1 : 0);

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b1;
  logic ClearA_LoadB = 1'b1;
  logic M;
  logic Clr_XA, Ld_XA, Ld_B, Shift_En, Fn, Busy, Done;

  int errors = 0;
  int checks = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_XA(Clr_XA), .Ld_XA(Ld_XA), .Ld_B(Ld_B), .Shift_En(Shift_En),
    .Fn(Fn), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Register-unit model: X:A:B and the 9-bit adder, driven by DUT controls.
  logic       x_r = 1'b0;
  logic [7:0] a_r = 8'h00;
  logic [7:0] b_r = 8'h00;
  logic [7:0] sw_b = 8'h00;
  logic [7:0] s_val = 8'h00;
  assign M = b_r[0];

  always @(posedge Clk) begin
    if (Ld_B) b_r <= sw_b;
    if (Clr_XA) begin
      x_r <= 1'b0;
      a_r <= 8'h00;
    end else if (Ld_XA) begin
      if (Fn) {x_r, a_r} <= {a_r[7], a_r} - {s_val[7], s_val};
      else    {x_r, a_r} <= {a_r[7], a_r} + {s_val[7], s_val};
    end else if (Shift_En) begin
      {x_r, a_r, b_r} <= {x_r, x_r, a_r, b_r[7:1]};
    end
  end

  // Behavioural model: mode 0 idle, 1 running, 2 holding product.
  // step counts cycles of a multiply: -1 clear, even = add, odd = shift.
  int m_mode = 0;
  int m_step = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode <= 0;
      m_step <= 0;
    end else begin
      case (m_mode)
        0: if (Run) begin
             m_mode <= 1;
             m_step <= AUTOCLR ? -1 : 0;
           end
        1: if (m_step == 2 * W - 1) m_mode <= 2;
           else m_step <= m_step + 1;
        2: if (!Run) m_mode <= 0;
        default: m_mode <= 0;
      endcase
    end
  end

  function automatic logic [6:0] model_outs();
    logic clr, ldxa, ldb, sh, fn, busy, done;
    clr = 1'b0; ldxa = 1'b0; ldb = 1'b0; sh = 1'b0; fn = 1'b0; busy = 1'b0; done = 1'b0;
    if (!Reset) begin
      if (m_mode == 0) begin
        ldb = ClearA_LoadB && !Run;
        clr = ClearA_LoadB && !Run;
      end else if (m_mode == 1) begin
        busy = 1'b1;
        if (m_step < 0) clr = 1'b1;
        else if (m_step % 2 == 0) begin
          ldxa = M;
          fn   = (m_step == 2 * W - 2);
        end else sh = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
    return {clr, ldxa, ldb, sh, fn, busy, done};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge Clk);
      check("cycle_outputs", 32'({Clr_XA, Ld_XA, Ld_B, Shift_En, Fn, Busy, Done}),
            32'(model_outs()));
    end
  end

  // Free-running pulse counters; tests take differences around a multiply.
  int n_ldxa = 0, n_sh = 0, n_fnld = 0;
  always @(negedge Clk) begin
    if (!Reset) begin
      n_ldxa <= n_ldxa + int'(Ld_XA);
      n_sh   <= n_sh + int'(Shift_En);
      n_fnld <= n_fnld + int'(Ld_XA & Fn);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_b(input logic [7:0] b);
    ClearA_LoadB = 1'b1;
    sw_b = b;
    @(negedge Clk);
    check("load_ldb", 32'(Ld_B), 32'd1);
    check("load_clr", 32'(Clr_XA), 32'd1);
    check("load_busy", 32'(Busy), 32'd0);
    tick();
    ClearA_LoadB = 1'b0;
    tick();
    check("load_one_cycle", 32'({Ld_B, Clr_XA}), 32'd0);
  endtask

  // exp_ldxa/exp_fnld < 0 skips that count; hold = extra cycles Run stays high after Done.
  task automatic run_mult(input string tag, input int exp_ldxa, input int exp_fnld,
                          input bit chk_prod, input logic [15:0] exp_prod, input int hold);
    int c, s_ld, s_sh, s_fl;
    s_ld = n_ldxa; s_sh = n_sh; s_fl = n_fnld;
    Run = 1'b1;
    c = 0;
    do begin
      tick();
      c++;
    end while (!Done && c < 200);
    check({tag, "_done_seen"}, 32'(Done), 32'd1);
    check({tag, "_latency"}, 32'(c - 1), 32'(LAT));
    check({tag, "_shifts"}, 32'(n_sh - s_sh), 32'(W));
    if (exp_ldxa >= 0) check({tag, "_ldxa"}, 32'(n_ldxa - s_ld), 32'(exp_ldxa));
    if (exp_fnld >= 0) check({tag, "_fn_sub"}, 32'(n_fnld - s_fl), 32'(exp_fnld));
    if (chk_prod) check({tag, "_product"}, 32'({a_r, b_r}), 32'(exp_prod));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_done"}, 32'(Done), 32'd1);
    end
    Run = 1'b0;
    tick();
    check({tag, "_back_idle"}, 32'({Busy, Done}), 32'd0);
  endtask

  initial begin
    // Reset held with Run and ClearA_LoadB high: all outputs must stay 0.
    sw_b = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("reset_outputs", 32'({Clr_XA, Ld_XA, Ld_B, Shift_En, Fn, Busy, Done}), 32'd0);
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    tick();
    check("idle_after_reset", 32'({Busy, Done}), 32'd0);

    // 7 * 5 = 35
    s_val = 8'h05;
    load_b(8'h07);
    run_mult("b07", 3, 0, 1'b1, 16'h0023, 0);

    // -128 * 3 = -384: only the final (subtract) add fires
    s_val = 8'h03;
    load_b(8'h80);
    run_mult("b80", 1, 1, 1'b1, 16'hFE80, 0);

    // -1 * 6 = -6
    s_val = 8'h06;
    load_b(8'hFF);
    run_mult("bff", 8, 1, 1'b1, 16'hFFFA, 0);

    // 5 * -3 = -15, with Run held after Done
    s_val = 8'hFD;
    load_b(8'h05);
    run_mult("b05", 2, 0, 1'b1, 16'hFFF1, 5);

    // Restart without reload: only the sequencing is checked
    run_mult("restart", -1, -1, 1'b0, 16'h0000, 0);

    // Reset during the 5th SHIFT cycle
    s_val = 8'h05;
    load_b(8'h07);
    Run = 1'b1;
    tick();
    for (int i = 0; i < 9 + (AUTOCLR ? 1 : 0); i++) tick();
    check("fifth_shift", 32'({Shift_En, Busy}), 32'h3);
    Reset = 1'b1;
    Run = 1'b0;
    @(negedge Clk);
    check("midrun_reset_outputs", 32'({Clr_XA, Ld_XA, Ld_B, Shift_En, Fn, Busy, Done}), 32'd0);
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("after_reset_idle", 32'({Busy, Done}), 32'd0);
    tick();
    load_b(8'h07);
    run_mult("post_reset", 3, 0, 1'b1, 16'h0023, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
